// File: rtl/ip_pkg.sv
// Shared IPv4 receive/transmit definitions: header constants, error codes and FSM states.
package ip_pkg;

    localparam logic [7:0] IP_VER_IHL   = 8'h45;
    localparam int         IP_HDR_LEN   = 20;
    localparam logic [7:0] IP_PROTO_UDP = 8'd17;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_VER_IHL = 3'd1,
        ERR_PROTO   = 3'd2,
        ERR_DEST    = 3'd3,
        ERR_CSUM    = 3'd4,
        ERR_TRUNC   = 3'd5
    } hdr_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_PAD,
        ST_DROP
    } rx_state_e;

endpackage

// File: rtl/rx_ip_if.sv
// Byte-wide AXI-Stream bundle with tuser start marker, as used around the IP receive path.
interface rx_ip_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ip_csum_acc.sv
// Byte-serial 16-bit ones'-complement accumulator; sum_o already includes the byte presented this cycle.
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        vld_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] sum_o
);

    logic [15:0] acc_q, acc_d, base;
    logic        odd_q, odd_d, odd_base;
    logic [16:0] add;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        base     = clr_i ? 16'd0 : acc_q;
        odd_base = clr_i ? 1'b0 : odd_q;
        add      = {1'b0, base} + (odd_base ? {9'd0, byte_i} : {1'b0, byte_i, 8'd0});
        acc_d    = base;
        odd_d    = odd_base;
        if (vld_i) begin
            // A single end-around fold suffices: the folded value cannot carry again.
            acc_d = add[15:0] + {15'd0, add[16]};
            odd_d = ~odd_base;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            odd_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            odd_q <= odd_d;
        end
    end

    assign sum_o = acc_d;

endmodule

// File: rtl/rx_ip.sv
// IPv4 receive header parser/stripper for a byte stream; forwards accepted UDP payload.
// Define RX_IP_CSUM_CHECK_EN to verify the header checksum (error code 4).
module rx_ip
    import ip_pkg::*;
#(
    parameter logic [7:0] ACCEPT_PROTO = IP_PROTO_UDP,
    parameter bit         CHECK_DEST   = 1'b1
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic        ip_enable,
    input  logic [31:0] local_ip_addr,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] IP_TotLen,
    output logic [31:0] IP_SrcAddr,
    output logic        hdr_ok,
    output logic [2:0]  hdr_err
);

    localparam logic [4:0]  LAST_HDR  = 5'(IP_HDR_LEN - 1);
    localparam logic [15:0] HDR_LEN16 = 16'(IP_HDR_LEN);

    rx_state_e   state_q, state_d;
    logic [4:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic        first_q, first_d;
    logic        ver_bad_q, ver_bad_d;
    logic [15:0] tot_len_q, tot_len_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [23:0] dst_q, dst_d;
    logic [15:0] ip_totlen_q, ip_totlen_d;
    logic [31:0] ip_src_q, ip_src_d;
    logic        hdr_ok_q, hdr_ok_d;
    hdr_err_e    hdr_err_q, hdr_err_d;
    hdr_err_e    hdr_code;
    logic [15:0] pay_len;
    logic        fire, start, csum_ok;

    assign fire  = s_axis_tvalid & s_axis_tready;
    assign start = ip_enable & (state_q == ST_IDLE) & fire & s_axis_tuser;

`ifdef RX_IP_CSUM_CHECK_EN
    logic [15:0] csum_sum;

    ip_csum_acc u_csum (
        .clk    (s_axis_aclk),
        .rst_n  (s_axis_aresetn),
        .clr_i  (start),
        .vld_i  (start | ((state_q == ST_HEADER) & fire)),
        .byte_i (s_axis_tdata),
        .sum_o  (csum_sum)
    );
    assign csum_ok = (csum_sum == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    // The last destination byte is judged straight off the bus, in the same cycle it arrives.
    always_comb begin
        pay_len = tot_len_q - HDR_LEN16;
        if (ver_bad_q || (tot_len_q < HDR_LEN16))                       hdr_code = ERR_VER_IHL;
        else if (proto_q != ACCEPT_PROTO)                                hdr_code = ERR_PROTO;
        else if (CHECK_DEST && ({dst_q, s_axis_tdata} != local_ip_addr)) hdr_code = ERR_DEST;
        else if (!csum_ok)                                               hdr_code = ERR_CSUM;
        else                                                             hdr_code = ERR_NONE;
    end

    always_comb begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = 1'b1;
        if (!ip_enable) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tuser  = s_axis_tuser;
            s_axis_tready = m_axis_tready;
        end else if (state_q == ST_DATA) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = (pay_cnt_q == 16'd1) | s_axis_tlast;
            m_axis_tuser  = first_q;
            s_axis_tready = m_axis_tready;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        first_d     = first_q;
        ver_bad_d   = ver_bad_q;
        tot_len_d   = tot_len_q;
        proto_d     = proto_q;
        src_d       = src_q;
        dst_d       = dst_q;
        ip_totlen_d = ip_totlen_q;
        ip_src_d    = ip_src_q;
        hdr_ok_d    = 1'b0;
        hdr_err_d   = ERR_NONE;

        case (state_q)
            ST_IDLE: if (start) begin
                if (s_axis_tlast) begin
                    hdr_err_d = ERR_TRUNC;
                end else begin
                    state_d   = ST_HEADER;
                    hdr_cnt_d = 5'd1;
                    ver_bad_d = (s_axis_tdata != IP_VER_IHL);
                end
            end
            ST_HEADER: if (fire) begin
                case (hdr_cnt_q)
                    5'd2:                      tot_len_d[15:8] = s_axis_tdata;
                    5'd3:                      tot_len_d[7:0]  = s_axis_tdata;
                    5'd9:                      proto_d         = s_axis_tdata;
                    5'd12, 5'd13, 5'd14, 5'd15: src_d          = {src_q[23:0], s_axis_tdata};
                    5'd16, 5'd17, 5'd18:       dst_d           = {dst_q[15:0], s_axis_tdata};
                    default: ;
                endcase
                if (hdr_cnt_q == LAST_HDR) begin
                    hdr_cnt_d = 5'd0;
                    if (hdr_code != ERR_NONE) begin
                        hdr_err_d = hdr_code;
                        state_d   = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else if (s_axis_tlast && (pay_len != 16'd0)) begin
                        hdr_err_d = ERR_TRUNC;
                        state_d   = ST_IDLE;
                    end else begin
                        hdr_ok_d    = 1'b1;
                        ip_totlen_d = tot_len_q;
                        ip_src_d    = src_q;
                        pay_cnt_d   = pay_len;
                        first_d     = 1'b1;
                        if (pay_len != 16'd0) state_d = ST_DATA;
                        else                  state_d = s_axis_tlast ? ST_IDLE : ST_PAD;
                    end
                end else if (s_axis_tlast) begin
                    hdr_cnt_d = 5'd0;
                    hdr_err_d = ERR_TRUNC;
                    state_d   = ST_IDLE;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 5'd1;
                end
            end
            ST_DATA: if (fire) begin
                pay_cnt_d = pay_cnt_q - 16'd1;
                first_d   = 1'b0;
                if (pay_cnt_q == 16'd1) begin
                    state_d = s_axis_tlast ? ST_IDLE : ST_PAD;
                end else if (s_axis_tlast) begin
                    pay_cnt_d = 16'd0;
                    hdr_err_d = ERR_TRUNC;
                    state_d   = ST_IDLE;
                end
            end
            ST_PAD, ST_DROP: if (fire && s_axis_tlast) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!ip_enable) begin
            state_d   = ST_IDLE;
            hdr_cnt_d = 5'd0;
            pay_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= ST_IDLE;
            hdr_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            first_q     <= 1'b0;
            ver_bad_q   <= 1'b0;
            tot_len_q   <= '0;
            proto_q     <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            ip_totlen_q <= '0;
            ip_src_q    <= '0;
            hdr_ok_q    <= 1'b0;
            hdr_err_q   <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            first_q     <= first_d;
            ver_bad_q   <= ver_bad_d;
            tot_len_q   <= tot_len_d;
            proto_q     <= proto_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            ip_totlen_q <= ip_totlen_d;
            ip_src_q    <= ip_src_d;
            hdr_ok_q    <= hdr_ok_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

    assign IP_TotLen  = ip_totlen_q;
    assign IP_SrcAddr = ip_src_q;
    assign hdr_ok     = hdr_ok_q;
    assign hdr_err    = hdr_err_q;

endmodule

// File: tb/tb_rx_ip.sv
// Directed bench for rx_ip: a frame table plus hand-written stall, reset and pass-through sequences.
module tb_rx_ip;
    import ip_pkg::*;

    localparam logic [31:0] LOCAL_IP = 32'hC0A80102;
    localparam logic [31:0] SRC_IP   = 32'hC0A8010A;
    localparam logic [31:0] OTHER_IP = 32'hC0A80103;

    typedef struct {
        logic [7:0]  proto;
        logic [31:0] dst;
        bit          flip;
        int          pay;
        int          pad;
        int          totlen;
        int          trunc;
        int          exp_n;
        int          exp_ok;
        logic [2:0]  exp_err;
        logic [7:0]  seed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ip_enable = 1'b1;
    logic [31:0] local_ip_addr = LOCAL_IP;
    logic        rdy_set = 1'b1;
    logic        tog_en = 1'b0;
    logic        tog_rdy = 1'b1;
    logic [15:0] ip_totlen;
    logic [31:0] ip_src;
    logic        hdr_ok;
    logic [2:0]  hdr_err;

    rx_ip_if s_if ();
    rx_ip_if m_if ();

    assign m_if.tready = tog_en ? tog_rdy : rdy_set;

    always #5 clk = ~clk;

    rx_ip dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .ip_enable      (ip_enable),
        .local_ip_addr  (local_ip_addr),
        .s_axis_tdata   (s_if.tdata),
        .s_axis_tvalid  (s_if.tvalid),
        .s_axis_tready  (s_if.tready),
        .s_axis_tlast   (s_if.tlast),
        .s_axis_tuser   (s_if.tuser),
        .m_axis_tdata   (m_if.tdata),
        .m_axis_tvalid  (m_if.tvalid),
        .m_axis_tready  (m_if.tready),
        .m_axis_tlast   (m_if.tlast),
        .m_axis_tuser   (m_if.tuser),
        .IP_TotLen      (ip_totlen),
        .IP_SrcAddr     (ip_src),
        .hdr_ok         (hdr_ok),
        .hdr_err        (hdr_err)
    );

    // Monitor: counters only ever grow; tests compare deltas against snapshots.
    logic [9:0] out_mem [0:1023];
    int         out_n = 0, ok_cnt = 0, err_cnt = 0, mirror_n = 0, mirror_bad = 0;
    logic [2:0] err_seen = 3'd0;

    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready) begin
            out_mem[out_n % 1024] = {m_if.tuser, m_if.tlast, m_if.tdata};
            out_n++;
        end
        if (hdr_ok) ok_cnt++;
        if (hdr_err != 3'd0) begin
            err_cnt++;
            err_seen = hdr_err;
        end
        if (ip_enable && m_if.tvalid) begin
            mirror_n++;
            if (s_if.tready !== m_if.tready) mirror_bad++;
        end
    end

    always @(posedge clk) begin
        int tog_i;
        #1;
        if (!tog_en) tog_i = 0;
        else begin
            tog_rdy = (tog_i == 0) || (tog_i == 3);
            tog_i   = (tog_i + 1) % 4;
        end
    end

    int total = 0, bad = 0;
    logic [7:0]  frm [0:127];
    int          frm_len;
    logic [15:0] exp_tl = 16'd0;
    logic [31:0] exp_src = 32'd0;
    vec_t        vt [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [7:0] proto, input logic [31:0] dst, input bit flip,
                         input int pay, input int pad, input int totlen, input logic [7:0] seed);
        logic [31:0] s;
        logic [15:0] tl;
        tl = 16'(totlen);
        frm[0] = 8'h45; frm[1] = 8'h00; frm[2] = tl[15:8]; frm[3] = tl[7:0];
        frm[4] = 8'h00; frm[5] = 8'h00; frm[6] = 8'h40;    frm[7] = 8'h00;
        frm[8] = 8'h40; frm[9] = proto; frm[10] = 8'h00;  frm[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            frm[12 + i] = SRC_IP[31 - 8 * i -: 8];
            frm[16 + i] = dst[31 - 8 * i -: 8];
        end
        s = 32'd0;
        for (int i = 0; i < 20; i += 2) s += {16'd0, frm[i], frm[i + 1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        frm[10] = ~s[15:8] ^ {7'd0, flip};
        frm[11] = ~s[7:0];
        for (int i = 0; i < pay; i++) frm[20 + i] = seed + 8'(i);
        for (int i = 0; i < pad; i++) frm[20 + pay + i] = 8'h00;
        frm_len = 20 + pay + pad;
    endtask

    task automatic put(input logic [7:0] d, input logic u, input logic l);
        int n;
        s_if.tdata = d; s_if.tuser = u; s_if.tlast = l; s_if.tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_if.tready && n < 200);
        if (n >= 200) check("put_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    endtask

    task automatic send_frame(input int trunc);
        for (int i = 0; i < frm_len; i++) begin
            put(frm[i], i == 0, (i == frm_len - 1) || (i == trunc));
            if (i == trunc) break;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int exp_n, input logic [7:0] seed,
                               input int exp_ok, input logic [2:0] exp_err,
                               input int b_out, input int b_ok, input int b_err);
        check({tag, "_count"}, 64'(out_n - b_out), 64'(exp_n));
        for (int i = 0; i < exp_n && i < out_n - b_out; i++)
            check({tag, "_byte"}, 64'(out_mem[(b_out + i) % 1024]),
                  64'({i == 0, i == exp_n - 1, seed + 8'(i)}));
        check({tag, "_ok"}, 64'(ok_cnt - b_ok), 64'(exp_ok));
        check({tag, "_errpulses"}, 64'(err_cnt - b_err), 64'(exp_err != 3'd0));
        if (exp_err != 3'd0) check({tag, "_errcode"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_totlen"}, 64'(ip_totlen), 64'(exp_tl));
        check({tag, "_src"}, 64'(ip_src), 64'(exp_src));
    endtask

    initial begin
        int b_out, b_ok, b_err, b_mn, b_mb;
        logic [2:0] csum_err;
        int csum_n, csum_ok;
`ifdef RX_IP_CSUM_CHECK_EN
        csum_err = 3'd4; csum_n = 0; csum_ok = 0;
`else
        csum_err = 3'd0; csum_n = 8; csum_ok = 1;
`endif
        vt[0]  = '{8'd17, LOCAL_IP, 1'b0, 8, 18, 28, -1, 8, 1, 3'd0, 8'h10};
        vt[1]  = '{8'd17, LOCAL_IP, 1'b1, 8, 18, 28, -1, csum_n, csum_ok, csum_err, 8'h20};
        vt[2]  = '{8'd6,  LOCAL_IP, 1'b0, 8, 18, 28, -1, 0, 0, 3'd2, 8'h30};
        vt[3]  = '{8'd17, LOCAL_IP, 1'b0, 8, 18, 28, -1, 8, 1, 3'd0, 8'h40};
        vt[4]  = '{8'd17, OTHER_IP, 1'b0, 8, 18, 28, -1, 0, 0, 3'd3, 8'h50};
        vt[5]  = '{8'd17, LOCAL_IP, 1'b0, 8, 0,  28, -1, 8, 1, 3'd0, 8'h60};
        vt[6]  = '{8'd17, LOCAL_IP, 1'b0, 8, 18, 28, 23, 4, 1, 3'd5, 8'h70};
        vt[7]  = '{8'd17, LOCAL_IP, 1'b0, 8, 18, 28, 10, 0, 0, 3'd5, 8'h80};
        vt[8]  = '{8'd17, LOCAL_IP, 1'b0, 0, 10, 16, -1, 0, 0, 3'd1, 8'h90};
        vt[9]  = '{8'd17, LOCAL_IP, 1'b0, 0, 6,  20, -1, 0, 1, 3'd0, 8'hA0};
        vt[10] = '{8'd17, LOCAL_IP, 1'b0, 0, 0,  20, 0,  0, 0, 3'd5, 8'hB0};
        vt[11] = '{8'd17, LOCAL_IP, 1'b0, 8, 18, 28, -1, 8, 1, 3'd0, 8'hC0};

        s_if.tdata = 8'h45; s_if.tlast = 1'b0; s_if.tuser = 1'b1; s_if.tvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_hdr_ok", 64'(hdr_ok), 64'd0);
        check("rst_hdr_err", 64'(hdr_err), 64'd0);
        check("rst_totlen", 64'(ip_totlen), 64'd0);
        check("rst_src", 64'(ip_src), 64'd0);
        s_if.tvalid = 1'b0; s_if.tuser = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 12; v++) begin
            build(vt[v].proto, vt[v].dst, vt[v].flip, vt[v].pay, vt[v].pad, vt[v].totlen, vt[v].seed);
            b_out = out_n; b_ok = ok_cnt; b_err = err_cnt;
            send_frame(vt[v].trunc);
            if (vt[v].exp_ok != 0) begin
                exp_tl = 16'(vt[v].totlen);
                exp_src = SRC_IP;
            end
            check_frame($sformatf("vec%0d", v), vt[v].exp_n, vt[v].seed, vt[v].exp_ok,
                        vt[v].exp_err, b_out, b_ok, b_err);
        end

        // Consumer stalls 1,0,0,1 during the payload.
        build(8'd17, LOCAL_IP, 1'b0, 8, 18, 28, 8'hD0);
        b_out = out_n; b_ok = ok_cnt; b_err = err_cnt; b_mn = mirror_n; b_mb = mirror_bad;
        tog_en = 1'b1;
        send_frame(-1);
        tog_en = 1'b0;
        check_frame("stall", 8, 8'hD0, 1, 3'd0, b_out, b_ok, b_err);
        check("stall_mirror", 64'(mirror_bad - b_mb), 64'd0);
        check("stall_seen", 64'(mirror_n - b_mn > 8), 64'd1);

        // Reset in the middle of a header, then a clean frame.
        build(8'd17, LOCAL_IP, 1'b0, 8, 18, 28, 8'hE0);
        b_out = out_n;
        for (int i = 0; i < 7; i++) put(frm[i], i == 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_totlen", 64'(ip_totlen), 64'd0);
        check("midrst_src", 64'(ip_src), 64'd0);
        check("midrst_mvalid", 64'(m_if.tvalid), 64'd0);
        rst_n = 1'b1;
        exp_tl = 16'd0; exp_src = 32'd0;
        @(posedge clk); #1;
        check("midrst_noout", 64'(out_n - b_out), 64'd0);
        b_out = out_n; b_ok = ok_cnt; b_err = err_cnt;
        send_frame(-1);
        exp_tl = 16'd28; exp_src = SRC_IP;
        check_frame("after_rst", 8, 8'hE0, 1, 3'd0, b_out, b_ok, b_err);

        // Pass-through: combinational copy with no parsing.
        ip_enable = 1'b0;
        b_ok = ok_cnt;
        for (int i = 0; i < 10; i++) begin
            s_if.tdata  = 8'($urandom);
            s_if.tvalid = 1'($urandom);
            s_if.tlast  = 1'($urandom);
            s_if.tuser  = 1'($urandom);
            rdy_set     = 1'($urandom);
            #3;
            check("bypass", 64'({m_if.tdata, m_if.tvalid, m_if.tlast, m_if.tuser, s_if.tready}),
                  64'({s_if.tdata, s_if.tvalid, s_if.tlast, s_if.tuser, rdy_set}));
        end
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0; rdy_set = 1'b1;
        @(posedge clk); #1;
        check("bypass_no_ok", 64'(ok_cnt - b_ok), 64'd0);
        ip_enable = 1'b1;
        build(8'd17, LOCAL_IP, 1'b0, 8, 18, 28, 8'hF0);
        b_out = out_n; b_ok = ok_cnt; b_err = err_cnt;
        send_frame(-1);
        check_frame("after_bypass", 8, 8'hF0, 1, 3'd0, b_out, b_ok, b_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
